// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single data-memory port between the pipeline
// (port P) and a secondary requester such as debug or DMA (port S).
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | no access outstanding; arbitrate between P and S
// REQ     | o_mem_req asserted, waiting for i_mem_ready
// RESP    | read accepted, waiting for i_mem_rvalid or the timeout
//
// Only o_p_stall is combinational. Every other output is registered.
module dmem_arbiter #(
    parameter int STARVE_MAX = 8,
    parameter int TIMEOUT    = 64
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_p_ren,
    input  logic        i_p_wen,
    input  logic [31:0] i_p_addr,
    input  logic [31:0] i_p_wdata,
    input  logic [3:0]  i_p_mask,
    output logic        o_p_stall,
    output logic        o_p_done,
    output logic [31:0] o_p_rdata,
    input  logic        i_s_vld,
    input  logic        i_s_wen,
    input  logic [31:0] i_s_addr,
    input  logic [31:0] i_s_wdata,
    input  logic [3:0]  i_s_mask,
    output logic        o_s_rdy,
    output logic        o_s_rvld,
    output logic [31:0] o_s_rdata,
    output logic        o_mem_req,
    output logic        o_mem_wen,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_mask,
    input  logic        i_mem_ready,
    input  logic        i_mem_rvalid,
    input  logic [31:0] i_mem_rdata,
    output logic        o_err
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    localparam logic OWN_P = 1'b0;
    localparam logic OWN_S = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic           owner_q, owner_d;
    logic [SW-1:0]  starve_q, starve_d;
    logic [TW-1:0]  tmo_q, tmo_d;

    logic           mem_req_d, mem_wen_d;
    logic [31:0]    mem_addr_d, mem_wdata_d;
    logic [3:0]     mem_mask_d;
    logic           p_done_d, s_rdy_d, s_rvld_d, err_d;
    logic [31:0]    p_rdata_d, s_rdata_d;

    logic           p_req, done_any, starve_hit, grant_s, grant_p;

    // The pipeline is released in the cycle its done pulse is visible.
    assign o_p_stall = (i_p_ren | i_p_wen) & ~o_p_done;

    // Arbitration terms. A done cycle never grants: the P request still on
    // the inputs is the one that just completed.
    always_comb begin
        p_req      = i_p_ren | i_p_wen;
        done_any   = o_p_done | o_s_rvld;
        starve_hit = (starve_q >= SW'(STARVE_MAX));
        grant_s    = i_s_vld & ~done_any & (~p_req | starve_hit);
        grant_p    = p_req & ~done_any & ~grant_s;
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        starve_d    = starve_q;
        tmo_d       = tmo_q;
        mem_req_d   = o_mem_req;
        mem_wen_d   = o_mem_wen;
        mem_addr_d  = o_mem_addr;
        mem_wdata_d = o_mem_wdata;
        mem_mask_d  = o_mem_mask;
        p_done_d    = 1'b0;
        s_rdy_d     = 1'b0;
        s_rvld_d    = 1'b0;
        err_d       = 1'b0;
        p_rdata_d   = o_p_rdata;
        s_rdata_d   = o_s_rdata;

        case (state_q)
            ST_IDLE: begin
                if (grant_s) begin
                    owner_d     = OWN_S;
                    mem_req_d   = 1'b1;
                    mem_wen_d   = i_s_wen;
                    mem_addr_d  = i_s_addr;
                    mem_wdata_d = i_s_wdata;
                    mem_mask_d  = i_s_mask;
                    s_rdy_d     = 1'b1;
                    starve_d    = '0;
                    state_d     = ST_REQ;
                end else begin
                    if (grant_p) begin
                        owner_d     = OWN_P;
                        mem_req_d   = 1'b1;
                        mem_wen_d   = i_p_wen;
                        mem_addr_d  = i_p_addr;
                        mem_wdata_d = i_p_wdata;
                        mem_mask_d  = i_p_mask;
                        state_d     = ST_REQ;
                    end
                    if (i_s_vld && !starve_hit) begin
                        starve_d = starve_q + SW'(1);
                    end
                end
            end

            ST_REQ: begin
                if (i_mem_ready) begin
                    mem_req_d = 1'b0;
                    if (o_mem_wen) begin
                        p_done_d = (owner_q == OWN_P);
                        s_rvld_d = (owner_q == OWN_S);
                        state_d  = ST_IDLE;
                    end else begin
                        // Loaded so the abort pulse lands TIMEOUT cycles
                        // after the accept cycle.
                        tmo_d   = TW'(TIMEOUT - 2);
                        state_d = ST_RESP;
                    end
                end
            end

            ST_RESP: begin
                if (i_mem_rvalid) begin
                    if (owner_q == OWN_P) begin
                        p_rdata_d = i_mem_rdata;
                        p_done_d  = 1'b1;
                    end else begin
                        s_rdata_d = i_mem_rdata;
                        s_rvld_d  = 1'b1;
                    end
                    state_d = ST_IDLE;
                end else if (tmo_q == '0) begin
                    err_d = 1'b1;
                    if (owner_q == OWN_P) begin
                        p_rdata_d = '0;
                        p_done_d  = 1'b1;
                    end else begin
                        s_rdata_d = '0;
                        s_rvld_d  = 1'b1;
                    end
                    state_d = ST_IDLE;
                end else begin
                    tmo_d = tmo_q - TW'(1);
                end
            end

            default: begin
                mem_req_d = 1'b0;
                state_d   = ST_IDLE;
            end
        endcase
    end

    // State, counters and registered outputs; reset aborts any access.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWN_P;
            starve_q    <= '0;
            tmo_q       <= '0;
            o_mem_req   <= 1'b0;
            o_mem_wen   <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_wdata <= '0;
            o_mem_mask  <= '0;
            o_p_done    <= 1'b0;
            o_p_rdata   <= '0;
            o_s_rdy     <= 1'b0;
            o_s_rvld    <= 1'b0;
            o_s_rdata   <= '0;
            o_err       <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            starve_q    <= starve_d;
            tmo_q       <= tmo_d;
            o_mem_req   <= mem_req_d;
            o_mem_wen   <= mem_wen_d;
            o_mem_addr  <= mem_addr_d;
            o_mem_wdata <= mem_wdata_d;
            o_mem_mask  <= mem_mask_d;
            o_p_done    <= p_done_d;
            o_p_rdata   <= p_rdata_d;
            o_s_rdy     <= s_rdy_d;
            o_s_rvld    <= s_rvld_d;
            o_s_rdata   <= s_rdata_d;
            o_err       <= err_d;
        end
    end

endmodule
